exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of FLUSH-state cycles after ISSUE (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on posedge.
REQ-003 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports wb_valid (in, 1) and wb_pc (in, 32): write-back instruction valid flag and its PC.
REQ-005 SHALL have ports wb_exc (in, 1), wb_excode (in, 6), wb_esubcode (in, 9), wb_badv (in, 32): synchronous exception info carried by the write-back instruction.
REQ-006 SHALL have ports wb_ertn (in, 1) and wb_refetch (in, 1): write-back instruction is ERTN, or is a TLB/CSR instruction that needs a refetch.
REQ-007 SHALL have ports is (in, 12), lie (in, 12), ie (in, 1): interrupt status, local enable and global enable from the CSR block.
REQ-008 SHALL have port wb_ready (out, 1): write-back stage may retire this cycle.
REQ-009 SHALL have port commit_ok (out, 1): the instruction retires architecturally (register-file write enable).
REQ-010 SHALL have ports is_exc, is_ertn, is_fetch_again (out, 1 each) and excode (out, 6), esubcode (out, 9), badvaddr (out, 32), csr_pc (out, 32): registered event bundle to the CSR block.
REQ-011 SHALL have port pipe_flush (out, 1): kill all younger in-flight instructions.
REQ-012 SHALL have port exc_cnt (out, 16): saturating count of issued events.

Function
REQ-013 SHALL implement states IDLE, ISSUE and FLUSH.
REQ-014 wb_ready SHALL be 1 only in IDLE.
REQ-015 An accept SHALL occur when wb_valid and wb_ready are both 1.
REQ-016 int_take SHALL equal ie AND OR-reduce(is AND lie), sampled only at an accept.
REQ-017 Event priority at an accept SHALL be: interrupt > wb_exc > wb_ertn > wb_refetch; the lower-priority flags are ignored.
REQ-018 An interrupt event SHALL drive excode 6'h00, esubcode 0, badvaddr 0, csr_pc wb_pc, is_exc 1.
REQ-019 An exception event SHALL drive is_exc 1 and pass wb_excode, wb_esubcode, wb_badv and wb_pc through unchanged.
REQ-020 An ERTN event SHALL drive is_ertn 1 with excode 0.
REQ-021 A refetch event SHALL drive is_fetch_again 1 with csr_pc wb_pc; the CSR block redirects to pc+4.
REQ-022 commit_ok SHALL be combinational: accept AND NOT int_take AND NOT wb_exc; ERTN and refetch instructions commit.
REQ-023 On an event accept in cycle T: event outputs SHALL be registered and valid in cycle T+1 only (single-cycle pulse), and state SHALL be ISSUE in T+1.
REQ-024 Excode, esubcode, badvaddr and csr_pc SHALL hold their last values when no pulse is active; is_* SHALL be 0.
REQ-025 ISSUE SHALL go to FLUSH after 1 cycle with a down-counter loaded to FLUSH_CYCLES-1.
REQ-026 FLUSH SHALL decrement the counter each cycle and return to IDLE in the cycle after the counter reads 0.
REQ-027 pipe_flush SHALL be 1 in ISSUE and FLUSH (cycles T+1..T+1+FLUSH_CYCLES) and 0 otherwise.
REQ-028 An accept with no event SHALL stay in IDLE, produce no pulse and leave pipe_flush at 0.
REQ-029 wb_valid=0 SHALL never start an event, even when int_take is 1.
REQ-030 exc_cnt SHALL increment by 1 on each ISSUE entry and saturate at 16'hFFFF.
REQ-031 Inputs presented outside IDLE SHALL be ignored.

Reset
REQ-032 resetn=0 SHALL immediately force state IDLE, flush counter 0, all event outputs 0, pipe_flush 0 and exc_cnt 0, regardless of clk.
REQ-033 While resetn=0, wb_ready and commit_ok SHALL be 0.
REQ-034 Reset asserted in ISSUE or FLUSH SHALL abort the sequence; the first cycle after release SHALL be IDLE.

Verification
REQ-035 Normal retire: wb_valid=1, no flags, is&lie=0 -> commit_ok=1, no pulse, pipe_flush=0, exc_cnt=0.
REQ-036 Exception: wb_exc=1, excode 6'h09, badv 32'h1234_5677, pc 32'h1C00_0100 -> commit_ok=0; next cycle is_exc=1 with those values; pipe_flush high 3 cycles (FLUSH_CYCLES=2); wb_ready=0 for those 3 cycles; exc_cnt=1.
REQ-037 Priority: ie=1, is=lie=12'h800, wb_exc=1, wb_ertn=1 -> is_exc=1, excode 0, is_ertn=0, commit_ok=0.
REQ-038 Interrupt masked by ie=0 with wb_ertn=1 -> is_ertn=1, commit_ok=1.
REQ-039 Back-to-back: new wb_exc held during FLUSH -> ignored; accepted in the first IDLE cycle; second pulse no earlier than T+4.
REQ-040 resetn dropped in the FLUSH state -> pipe_flush=0 immediately; exc_cnt=0; wb_ready=1 in the first post-release cycle.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: write-back exception/interrupt/ERTN/refetch arbiter with one-cycle CSR event pulse and timed pipeline flush.
module exc_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_exc,
    input  logic [5:0]  wb_excode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_badv,
    input  logic        wb_ertn,
    input  logic        wb_refetch,
    input  logic [11:0] is,
    input  logic [11:0] lie,
    input  logic        ie,
    output logic        wb_ready,
    output logic        commit_ok,
    output logic        is_exc,
    output logic        is_ertn,
    output logic        is_fetch_again,
    output logic [5:0]  excode,
    output logic [8:0]  esubcode,
    output logic [31:0] badvaddr,
    output logic [31:0] csr_pc,
    output logic        pipe_flush,
    output logic [15:0] exc_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic accept, int_take, take_exc, ev, sync_exc;
    // wb_ready is gated by resetn so nothing retires while reset is held
    assign wb_ready   = resetn && state == IDLE;
    assign accept     = wb_valid && wb_ready;
    assign int_take   = ie && |(is & lie);
    assign take_exc   = int_take || wb_exc;
    assign sync_exc   = wb_exc && !int_take;
    assign ev         = accept && (take_exc || wb_ertn || wb_refetch);
    assign commit_ok  = accept && !take_exc;
    assign pipe_flush = state != IDLE;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:  state_nx = ev ? ISSUE : IDLE;
            ISSUE: begin
                state_nx = FLUSH;
                cnt_nx   = CNT_INIT;
            end
            FLUSH: begin
                state_nx = cnt == 4'd0 ? IDLE : FLUSH;
                cnt_nx   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_exc         <= 1'b0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            excode         <= 6'h00;
            esubcode       <= 9'h000;
            badvaddr       <= 32'h0;
            csr_pc         <= 32'h0;
            exc_cnt        <= 16'h0;
        end else begin
            is_exc         <= ev && take_exc;
            is_ertn        <= ev && !take_exc && wb_ertn;
            is_fetch_again <= ev && !take_exc && !wb_ertn && wb_refetch;
            if (ev) begin
                excode   <= sync_exc ? wb_excode : 6'h00;
                esubcode <= sync_exc ? wb_esubcode : 9'h000;
                badvaddr <= sync_exc ? wb_badv : 32'h0;
                csr_pc   <= wb_pc;
                exc_cnt  <= exc_cnt == 16'hFFFF ? exc_cnt : exc_cnt + 16'h1;
            end
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and randomized checks of exc_ctrl against a transaction-level model.
module tb_exc_ctrl;
    localparam int FC = 2;
    logic        clk, resetn;
    logic        wb_valid, wb_exc, wb_ertn, wb_refetch, ie;
    logic [31:0] wb_pc, wb_badv;
    logic [5:0]  wb_excode;
    logic [8:0]  wb_esubcode;
    logic [11:0] is, lie;
    logic        wb_ready, commit_ok, is_exc, is_ertn, is_fetch_again, pipe_flush;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr, csr_pc;
    logic [15:0] exc_cnt;

    int checks = 0, failures = 0;

    // model: cycles left until IDLE, pending pulse, last event fields (with known flags)
    int          m_busy, m_cnt;
    bit          m_exc, m_ertn, m_fa, k_code, k_sub, k_badv, k_pc;
    logic [5:0]  m_excode;
    logic [8:0]  m_esub;
    logic [31:0] m_badv, m_pc;

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_exc(wb_exc), .wb_excode(wb_excode), .wb_esubcode(wb_esubcode), .wb_badv(wb_badv),
        .wb_ertn(wb_ertn), .wb_refetch(wb_refetch), .is(is), .lie(lie), .ie(ie),
        .wb_ready(wb_ready), .commit_ok(commit_ok), .is_exc(is_exc), .is_ertn(is_ertn),
        .is_fetch_again(is_fetch_again), .excode(excode), .esubcode(esubcode),
        .badvaddr(badvaddr), .csr_pc(csr_pc), .pipe_flush(pipe_flush), .exc_cnt(exc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_in();
        wb_valid = 0; wb_exc = 0; wb_ertn = 0; wb_refetch = 0; ie = 0;
        wb_pc = 0; wb_badv = 0; wb_excode = 0; wb_esubcode = 0; is = 0; lie = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_exc = 0; m_ertn = 0; m_fa = 0;
        m_excode = 0; m_esub = 0; m_badv = 0; m_pc = 0;
        k_code = 1; k_sub = 1; k_badv = 1; k_pc = 1;
    endtask

    // advance the model by one clock from the currently driven inputs, then step the DUT
    task automatic cyc();
        bit it, acc, ev;
        it  = ie && ((is & lie) != 12'h0);
        acc = wb_valid && resetn && m_busy == 0;
        ev  = acc && (it || wb_exc || wb_ertn || wb_refetch);
        m_exc = 0; m_ertn = 0; m_fa = 0;
        if (m_busy > 0) m_busy--;
        if (ev) begin
            m_busy = FC + 1;
            m_cnt  = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
            m_pc = wb_pc; k_pc = 1;
            if (it) begin
                m_exc = 1; m_excode = 0; m_esub = 0; m_badv = 0;
                k_code = 1; k_sub = 1; k_badv = 1;
            end else if (wb_exc) begin
                m_exc = 1; m_excode = wb_excode; m_esub = wb_esubcode; m_badv = wb_badv;
                k_code = 1; k_sub = 1; k_badv = 1;
            end else if (wb_ertn) begin
                m_ertn = 1; m_excode = 0;
                k_code = 1; k_sub = 0; k_badv = 0; k_pc = 0;
            end else begin
                m_fa = 1; k_code = 0; k_sub = 0; k_badv = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle_in();
        model_reset();
        @(posedge clk); #1;
        resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0; idle_in(); wb_valid = 1; model_reset();
        #1;
        checks += 7;
        if (wb_ready !== 1'b0) begin failures++; $display("FAIL rst_wb_ready got=%b exp=0", wb_ready); end
        if (commit_ok !== 1'b0) begin failures++; $display("FAIL rst_commit_ok got=%b exp=0", commit_ok); end
        if (pipe_flush !== 1'b0) begin failures++; $display("FAIL rst_pipe_flush got=%b exp=0", pipe_flush); end
        if ({is_exc, is_ertn, is_fetch_again} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%b exp=000", {is_exc, is_ertn, is_fetch_again}); end
        if (exc_cnt !== 16'h0) begin failures++; $display("FAIL rst_exc_cnt got=%h exp=0", exc_cnt); end
        if ({excode, esubcode} !== 15'h0) begin failures++; $display("FAIL rst_codes got=%h exp=0", {excode, esubcode}); end
        if ({badvaddr, csr_pc} !== 64'h0) begin failures++; $display("FAIL rst_addrs got=%h exp=0", {badvaddr, csr_pc}); end
        @(posedge clk); #1;
        resetn = 1; idle_in();
        @(negedge clk);
        checks++;
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", wb_ready); end
    endtask

    task automatic test_normal();
        do_reset();
        wb_valid = 1; wb_pc = 32'h1C00_0040;
        @(negedge clk);
        checks += 2;
        if (commit_ok !== 1'b1) begin failures++; $display("FAIL normal_commit got=%b exp=1", commit_ok); end
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL normal_ready got=%b exp=1", wb_ready); end
        cyc();
        idle_in(); ie = 1; is = 12'h001; lie = 12'h001;
        @(negedge clk);
        checks += 4;
        if ({is_exc, is_ertn, is_fetch_again} !== 3'b000) begin failures++; $display("FAIL normal_pulse got=%b exp=000", {is_exc, is_ertn, is_fetch_again}); end
        if (pipe_flush !== 1'b0) begin failures++; $display("FAIL normal_flush got=%b exp=0", pipe_flush); end
        if (exc_cnt !== 16'h0) begin failures++; $display("FAIL normal_cnt got=%h exp=0", exc_cnt); end
        if (commit_ok !== 1'b0) begin failures++; $display("FAIL novalid_commit got=%b exp=0", commit_ok); end
        cyc();
        idle_in();
        @(negedge clk);
        checks += 2;
        if (is_exc !== 1'b0) begin failures++; $display("FAIL novalid_int_pulse got=%b exp=0", is_exc); end
        if (pipe_flush !== 1'b0) begin failures++; $display("FAIL novalid_int_flush got=%b exp=0", pipe_flush); end
    endtask

    task automatic test_exception();
        do_reset();
        wb_valid = 1; wb_exc = 1; wb_excode = 6'h09; wb_esubcode = 9'h003;
        wb_badv = 32'h1234_5677; wb_pc = 32'h1C00_0100;
        @(negedge clk);
        checks++;
        if (commit_ok !== 1'b0) begin failures++; $display("FAIL exc_commit got=%b exp=0", commit_ok); end
        cyc();
        idle_in();
        @(negedge clk);
        checks += 5;
        if (is_exc !== 1'b1) begin failures++; $display("FAIL exc_pulse got=%b exp=1", is_exc); end
        if (excode !== 6'h09) begin failures++; $display("FAIL exc_excode got=%h exp=09", excode); end
        if (esubcode !== 9'h003) begin failures++; $display("FAIL exc_esub got=%h exp=003", esubcode); end
        if (badvaddr !== 32'h1234_5677) begin failures++; $display("FAIL exc_badv got=%h exp=12345677", badvaddr); end
        if (csr_pc !== 32'h1C00_0100) begin failures++; $display("FAIL exc_pc got=%h exp=1c000100", csr_pc); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks += 2;
            if (pipe_flush !== 1'b1) begin failures++; $display("FAIL exc_flush_c%0d got=%b exp=1", k, pipe_flush); end
            if (wb_ready !== 1'b0) begin failures++; $display("FAIL exc_ready_c%0d got=%b exp=0", k, wb_ready); end
            if (k == 1) begin
                checks += 2;
                if (is_exc !== 1'b0) begin failures++; $display("FAIL exc_pulse_len got=%b exp=0", is_exc); end
                if (excode !== 6'h09) begin failures++; $display("FAIL exc_hold got=%h exp=09", excode); end
            end
            cyc();
        end
        @(negedge clk);
        checks += 3;
        if (pipe_flush !== 1'b0) begin failures++; $display("FAIL exc_flush_end got=%b exp=0", pipe_flush); end
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL exc_ready_end got=%b exp=1", wb_ready); end
        if (exc_cnt !== 16'd1) begin failures++; $display("FAIL exc_cnt got=%h exp=1", exc_cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        wb_valid = 1; ie = 1; is = 12'h800; lie = 12'h800; wb_exc = 1; wb_excode = 6'h05;
        wb_badv = 32'hDEAD_BEEF; wb_ertn = 1; wb_pc = 32'h1C00_0200;
        @(negedge clk);
        checks++;
        if (commit_ok !== 1'b0) begin failures++; $display("FAIL prio_commit got=%b exp=0", commit_ok); end
        cyc();
        idle_in();
        @(negedge clk);
        checks += 4;
        if (is_exc !== 1'b1) begin failures++; $display("FAIL prio_is_exc got=%b exp=1", is_exc); end
        if (is_ertn !== 1'b0) begin failures++; $display("FAIL prio_is_ertn got=%b exp=0", is_ertn); end
        if (excode !== 6'h00) begin failures++; $display("FAIL prio_excode got=%h exp=00", excode); end
        if (csr_pc !== 32'h1C00_0200) begin failures++; $display("FAIL prio_pc got=%h exp=1c000200", csr_pc); end
        do_reset();
        wb_valid = 1; ie = 0; is = 12'h800; lie = 12'h800; wb_ertn = 1;
        @(negedge clk);
        checks++;
        if (commit_ok !== 1'b1) begin failures++; $display("FAIL mask_commit got=%b exp=1", commit_ok); end
        cyc();
        idle_in();
        @(negedge clk);
        checks += 3;
        if (is_ertn !== 1'b1) begin failures++; $display("FAIL mask_is_ertn got=%b exp=1", is_ertn); end
        if (is_exc !== 1'b0) begin failures++; $display("FAIL mask_is_exc got=%b exp=0", is_exc); end
        if (excode !== 6'h00) begin failures++; $display("FAIL mask_excode got=%h exp=00", excode); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_valid = 1; wb_exc = 1; wb_excode = 6'h01; wb_pc = 32'hA000_0000;
        @(negedge clk);
        cyc();
        wb_excode = 6'h02; wb_pc = 32'hB000_0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks += 3;
            if (is_exc !== (k == 1)) begin failures++; $display("FAIL b2b_pulse_t%0d got=%b exp=%b", k, is_exc, k == 1); end
            if (wb_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_t%0d got=%b exp=0", k, wb_ready); end
            if (commit_ok !== 1'b0) begin failures++; $display("FAIL b2b_commit_t%0d got=%b exp=0", k, commit_ok); end
            cyc();
        end
        @(negedge clk);
        checks += 2;
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_t4 got=%b exp=1", wb_ready); end
        if (is_exc !== 1'b0) begin failures++; $display("FAIL b2b_pulse_t4 got=%b exp=0", is_exc); end
        cyc();
        idle_in();
        @(negedge clk);
        checks += 4;
        if (is_exc !== 1'b1) begin failures++; $display("FAIL b2b_pulse_t5 got=%b exp=1", is_exc); end
        if (excode !== 6'h02) begin failures++; $display("FAIL b2b_excode got=%h exp=02", excode); end
        if (csr_pc !== 32'hB000_0000) begin failures++; $display("FAIL b2b_pc got=%h exp=b0000000", csr_pc); end
        if (exc_cnt !== 16'd2) begin failures++; $display("FAIL b2b_cnt got=%h exp=2", exc_cnt); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        wb_valid = 1; wb_refetch = 1; wb_pc = 32'h1C00_0300;
        @(negedge clk);
        cyc();
        idle_in();
        @(negedge clk);
        checks++;
        if (is_fetch_again !== 1'b1) begin failures++; $display("FAIL rif_refetch got=%b exp=1", is_fetch_again); end
        cyc();
        #2;
        resetn = 0;
        #1;
        checks += 3;
        if (pipe_flush !== 1'b0) begin failures++; $display("FAIL rif_flush got=%b exp=0", pipe_flush); end
        if (exc_cnt !== 16'h0) begin failures++; $display("FAIL rif_cnt got=%h exp=0", exc_cnt); end
        if (wb_ready !== 1'b0) begin failures++; $display("FAIL rif_ready_in_rst got=%b exp=0", wb_ready); end
        @(negedge clk);
        resetn = 1;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL rif_ready_after got=%b exp=1", wb_ready); end
        if (pipe_flush !== 1'b0) begin failures++; $display("FAIL rif_flush_after got=%b exp=0", pipe_flush); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            wb_valid    = $urandom_range(0, 9) < 7;
            wb_exc      = $urandom_range(0, 9) < 2;
            wb_ertn     = $urandom_range(0, 9) < 2;
            wb_refetch  = $urandom_range(0, 9) < 2;
            ie          = $urandom_range(0, 3) == 0;
            is          = 12'($urandom);
            lie         = 12'($urandom);
            wb_pc       = $urandom;
            wb_badv     = $urandom;
            wb_excode   = 6'($urandom);
            wb_esubcode = 9'($urandom);
            @(negedge clk);
            checks += 7;
            if (wb_ready !== (m_busy == 0)) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=%b", n, wb_ready, m_busy == 0); end
            if (pipe_flush !== (m_busy > 0)) begin failures++; $display("FAIL rnd%0d_flush got=%b exp=%b", n, pipe_flush, m_busy > 0); end
            if (commit_ok !== (wb_valid && m_busy == 0 && !(ie && (is & lie) != 0) && !wb_exc))
                begin failures++; $display("FAIL rnd%0d_commit got=%b", n, commit_ok); end
            if (is_exc !== m_exc) begin failures++; $display("FAIL rnd%0d_is_exc got=%b exp=%b", n, is_exc, m_exc); end
            if (is_ertn !== m_ertn) begin failures++; $display("FAIL rnd%0d_is_ertn got=%b exp=%b", n, is_ertn, m_ertn); end
            if (is_fetch_again !== m_fa) begin failures++; $display("FAIL rnd%0d_is_fa got=%b exp=%b", n, is_fetch_again, m_fa); end
            if (exc_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", n, exc_cnt, m_cnt); end
            if (k_code) begin checks++; if (excode !== m_excode) begin failures++; $display("FAIL rnd%0d_excode got=%h exp=%h", n, excode, m_excode); end end
            if (k_sub) begin checks++; if (esubcode !== m_esub) begin failures++; $display("FAIL rnd%0d_esub got=%h exp=%h", n, esubcode, m_esub); end end
            if (k_badv) begin checks++; if (badvaddr !== m_badv) begin failures++; $display("FAIL rnd%0d_badv got=%h exp=%h", n, badvaddr, m_badv); end end
            if (k_pc) begin checks++; if (csr_pc !== m_pc) begin failures++; $display("FAIL rnd%0d_pc got=%h exp=%h", n, csr_pc, m_pc); end end
            cyc();
        end
    endtask

    initial begin
        resetn = 0;
        idle_in();
        model_reset();
        test_reset();
        test_normal();
        test_exception();
        test_priority();
        test_back_to_back();
        test_reset_in_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
